// File: rtl/cardinal_run_monitor.sv
// Run controller/observer: counts cycles per core until each core fetches HALT_INST,
// waits out the pipeline flush, then streams every core's dmem through a valid/ready port.
module cardinal_run_monitor #(
  parameter int NUM_CORES = 4,
  parameter int INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] HALT_INST = INST_WIDTH'(32'h00000000),
  parameter int CNT_WIDTH = 32,
  parameter int FLUSH_CYCLES = 5,
  parameter int TIMEOUT = 100000,
  parameter int DUMP_DEPTH = 128,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 64,
  parameter int CORE_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [NUM_CORES*INST_WIDTH-1:0] inst_in,
  output logic [NUM_CORES-1:0]            core_halted,
  output logic [NUM_CORES*CNT_WIDTH-1:0]  cycle_count,
  output logic [CNT_WIDTH-1:0]            total_cycles,
  output logic                            busy,
  output logic                            done,
  output logic                            timed_out,
  output logic                            mem_rd_en,
  output logic [CORE_W-1:0]               mem_core_sel,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  input  logic [DATA_WIDTH-1:0]           mem_rd_data,
  output logic                            dump_valid,
  input  logic                            dump_ready,
  output logic [DATA_WIDTH-1:0]           dump_data,
  output logic [CORE_W-1:0]               dump_core,
  output logic [ADDR_WIDTH-1:0]           dump_addr,
  output logic                            dump_last
);

  localparam int FL_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [CORE_W-1:0]     LAST_CORE   = CORE_W'(NUM_CORES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DUMP_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0]  TIMEOUT_CNT = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [FL_W-1:0]       FLUSH_LAST  = FL_W'(FLUSH_CYCLES - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_RUN, ST_FLUSH, ST_DUMP, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  total_q, total_d;
  logic                  timed_out_q, timed_out_d;
  logic [FL_W-1:0]       flush_cnt_q, flush_cnt_d;
  logic [CORE_W-1:0]     core_ptr_q, core_ptr_d;
  logic [ADDR_WIDTH-1:0] addr_ptr_q, addr_ptr_d;
  logic                  reads_done_q, reads_done_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [CORE_W-1:0]     rd_core_q, rd_core_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  dump_valid_q, dump_valid_d;
  logic [DATA_WIDTH-1:0] dump_data_q, dump_data_d;
  logic [CORE_W-1:0]     dump_core_q, dump_core_d;
  logic [ADDR_WIDTH-1:0] dump_addr_q, dump_addr_d;
  logic                  dump_last_q, dump_last_d;

  logic [NUM_CORES-1:0]  halted_d;
  logic                  start_go;
  logic                  in_run;
  logic                  all_halted_d;
  logic                  timeout_hit;
  logic                  accept;

  assign start_go     = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign in_run       = (state_q == ST_RUN);
  assign all_halted_d = &halted_d;
  // A core halting on the timeout cycle that completes the set is a normal finish.
  assign timeout_hit  = in_run && (total_q == TIMEOUT_CNT) && !all_halted_d;
  assign accept       = dump_valid_q && dump_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CORES; gi++) begin : g_core
      logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
      logic                 halt_q, halt_d;
      logic                 halt_fetch;

      assign halt_fetch = (inst_in[gi*INST_WIDTH +: INST_WIDTH] == HALT_INST);
      assign halt_d = start_go ? 1'b0 :
                      (in_run && !halt_q && halt_fetch) ? 1'b1 : halt_q;

      always_comb begin
        cnt_d = cnt_q;
        if (start_go) begin
          cnt_d = '0;
        end else if (in_run && !halt_q && !halt_fetch && !timeout_hit && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_q  <= '0;
          halt_q <= 1'b0;
        end else begin
          cnt_q  <= cnt_d;
          halt_q <= halt_d;
        end
      end

      assign halted_d[gi] = halt_d;
      assign core_halted[gi] = halt_q;
      assign cycle_count[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    total_d      = total_q;
    timed_out_d  = timed_out_q;
    flush_cnt_d  = flush_cnt_q;
    core_ptr_d   = core_ptr_q;
    addr_ptr_d   = addr_ptr_q;
    reads_done_d = reads_done_q;
    rd_pend_d    = 1'b0;
    rd_core_d    = rd_core_q;
    rd_addr_d    = rd_addr_q;
    dump_valid_d = dump_valid_q;
    dump_data_d  = dump_data_q;
    dump_core_d  = dump_core_q;
    dump_addr_d  = dump_addr_q;
    dump_last_d  = dump_last_q;
    mem_rd_en    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d     = ST_RUN;
          total_d     = '0;
          timed_out_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (total_q != '1) total_d = total_q + 1'b1;
        if (all_halted_d) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
        end else if (timeout_hit) begin
          state_d     = ST_FLUSH;
          flush_cnt_d = '0;
          timed_out_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (flush_cnt_q == FLUSH_LAST) begin
          state_d      = ST_DUMP;
          core_ptr_d   = '0;
          addr_ptr_d   = '0;
          reads_done_d = 1'b0;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      ST_DUMP: begin
        // Only issue when the output register is free by the time the data returns.
        mem_rd_en = !rd_pend_q && !reads_done_q && (!dump_valid_q || dump_ready);
        if (mem_rd_en) begin
          rd_pend_d = 1'b1;
          rd_core_d = core_ptr_q;
          rd_addr_d = addr_ptr_q;
          if (addr_ptr_q == LAST_ADDR) begin
            addr_ptr_d = '0;
            if (core_ptr_q == LAST_CORE) reads_done_d = 1'b1;
            else core_ptr_d = core_ptr_q + 1'b1;
          end else begin
            addr_ptr_d = addr_ptr_q + 1'b1;
          end
        end
        if (rd_pend_q) begin
          dump_valid_d = 1'b1;
          dump_data_d  = mem_rd_data;
          dump_core_d  = rd_core_q;
          dump_addr_d  = rd_addr_q;
          dump_last_d  = (rd_core_q == LAST_CORE) && (rd_addr_q == LAST_ADDR);
        end else if (accept) begin
          dump_valid_d = 1'b0;
          dump_last_d  = 1'b0;
        end
        if (accept && dump_last_q) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      total_q      <= '0;
      timed_out_q  <= 1'b0;
      flush_cnt_q  <= '0;
      core_ptr_q   <= '0;
      addr_ptr_q   <= '0;
      reads_done_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      rd_core_q    <= '0;
      rd_addr_q    <= '0;
      dump_valid_q <= 1'b0;
      dump_data_q  <= '0;
      dump_core_q  <= '0;
      dump_addr_q  <= '0;
      dump_last_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      total_q      <= total_d;
      timed_out_q  <= timed_out_d;
      flush_cnt_q  <= flush_cnt_d;
      core_ptr_q   <= core_ptr_d;
      addr_ptr_q   <= addr_ptr_d;
      reads_done_q <= reads_done_d;
      rd_pend_q    <= rd_pend_d;
      rd_core_q    <= rd_core_d;
      rd_addr_q    <= rd_addr_d;
      dump_valid_q <= dump_valid_d;
      dump_data_q  <= dump_data_d;
      dump_core_q  <= dump_core_d;
      dump_addr_q  <= dump_addr_d;
      dump_last_q  <= dump_last_d;
    end
  end

  assign busy         = (state_q == ST_RUN) || (state_q == ST_FLUSH) || (state_q == ST_DUMP);
  assign done         = (state_q == ST_DONE);
  assign timed_out    = timed_out_q;
  assign total_cycles = total_q;
  assign mem_core_sel = core_ptr_q;
  assign mem_addr     = addr_ptr_q;
  assign dump_valid   = dump_valid_q;
  assign dump_data    = dump_data_q;
  assign dump_core    = dump_core_q;
  assign dump_addr    = dump_addr_q;
  assign dump_last    = dump_last_q;

endmodule

// File: tb/tb_cardinal_run_monitor.sv
// Directed bench for cardinal_run_monitor: two cores, short timeout and dump depth,
// with a dmem model and a scoreboard of expected dump words.
module tb_cardinal_run_monitor;
  localparam int NC  = 2;
  localparam int IW  = 32;
  localparam int CW  = 32;
  localparam int FC  = 5;
  localparam int TO  = 50;
  localparam int DD  = 4;
  localparam int AW  = 8;
  localparam int DW  = 64;
  localparam int CRW = 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [NC*IW-1:0]     inst_in;
  logic [NC-1:0]        core_halted;
  logic [NC*CW-1:0]     cycle_count;
  logic [CW-1:0]        total_cycles;
  logic                 busy, done, timed_out, mem_rd_en;
  logic [CRW-1:0]       mem_core_sel;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_rd_data;
  logic                 dump_valid, dump_ready, dump_last;
  logic [DW-1:0]        dump_data;
  logic [CRW-1:0]       dump_core;
  logic [AW-1:0]        dump_addr;

  int checks = 0;
  int failures = 0;
  logic [15:0] seed;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [CRW-1:0] core;
    logic [AW-1:0]  addr;
    logic           last;
  } word_t;
  word_t exp_q[$];

  cardinal_run_monitor #(
    .NUM_CORES(NC), .INST_WIDTH(IW), .HALT_INST(32'h00000000), .CNT_WIDTH(CW),
    .FLUSH_CYCLES(FC), .TIMEOUT(TO), .DUMP_DEPTH(DD), .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW), .CORE_W(CRW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .inst_in(inst_in),
    .core_halted(core_halted), .cycle_count(cycle_count), .total_cycles(total_cycles),
    .busy(busy), .done(done), .timed_out(timed_out), .mem_rd_en(mem_rd_en),
    .mem_core_sel(mem_core_sel), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_core(dump_core), .dump_addr(dump_addr), .dump_last(dump_last)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] word_of(input logic [15:0] s, input int c, input int a);
    return {s, 16'hD0D0, 8'(c), 8'(a), 16'(a * 37 + c * 11 + 5)};
  endfunction

  // dmem model: registered read, data one cycle after the strobe
  always @(posedge clk) begin
    if (reset) mem_rd_data <= '0;
    else if (mem_rd_en) mem_rd_data <= word_of(seed, int'(mem_core_sel), int'(mem_addr));
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_inst(input int k, input int h0, input int h1);
    inst_in[0 +: IW]  = (k == h0) ? 32'h00000000 : 32'h00000013 + 32'(k);
    inst_in[IW +: IW] = (k == h1) ? 32'h00000000 : 32'h00100093 + 32'(k);
  endtask

  task automatic check_zero_outputs(input string name);
    chk({name, ".busy"}, busy, 0);
    chk({name, ".done"}, done, 0);
    chk({name, ".timed_out"}, timed_out, 0);
    chk({name, ".core_halted"}, core_halted, 0);
    chk({name, ".cycle_count"}, cycle_count, 0);
    chk({name, ".total_cycles"}, total_cycles, 0);
    chk({name, ".mem_rd_en"}, mem_rd_en, 0);
    chk({name, ".dump_valid"}, dump_valid, 0);
    chk({name, ".dump_last"}, dump_last, 0);
  endtask

  // h<0 means the core never halts; abort_after>0 stops after that many accepted words
  task automatic run_case(input string name, input int h0, input int h1, input bit stall,
                          input int abort_after, input logic [15:0] sd);
    int end_cyc, c0, c1, k, cyc, n_acc, first_rd, last_acc, stall_left;
    bit to, finished, prev_hold;
    logic [DW-1:0] pd_data;
    logic [CRW-1:0] pd_core;
    logic [AW-1:0] pd_addr;
    logic pd_last;
    word_t e;

    if (h0 >= 0 && h0 <= TO - 1 && h1 >= 0 && h1 <= TO - 1) begin
      end_cyc = (h0 > h1) ? h0 : h1;
      to = 1'b0;
    end else begin
      end_cyc = TO - 1;
      to = 1'b1;
    end
    c0 = (h0 >= 0 && h0 <= end_cyc) ? h0 : end_cyc;
    c1 = (h1 >= 0 && h1 <= end_cyc) ? h1 : end_cyc;

    seed = sd;
    for (int c = 0; c < NC; c++)
      for (int a = 0; a < DD; a++)
        exp_q.push_back('{word_of(sd, c, a), CRW'(c), AW'(a), (c == NC - 1) && (a == DD - 1)});

    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    k = 0;
    while (k < TO + 10) begin
      drive_inst(k, h0, h1);
      @(posedge clk); #1;
      k++;
      if ((&core_halted) || timed_out) break;
    end
    chk({name, ".run_len"}, k, end_cyc + 1);
    chk({name, ".core_halted"}, core_halted,
        {62'd0, (h1 >= 0 && h1 <= end_cyc), (h0 >= 0 && h0 <= end_cyc)});
    chk({name, ".cycle_count"}, cycle_count, {32'(c1), 32'(c0)});
    chk({name, ".total_cycles"}, total_cycles, end_cyc + 1);
    chk({name, ".timed_out"}, timed_out, to);
    chk({name, ".busy"}, busy, 1);

    n_acc = 0; first_rd = -1; last_acc = -1; cyc = 0; finished = 1'b0; prev_hold = 1'b0;
    stall_left = stall ? 3 : 0;
    pd_data = '0; pd_core = '0; pd_addr = '0; pd_last = 1'b0;
    while (cyc < 200) begin
      if (stall && dump_valid && n_acc == 2 && stall_left > 0) begin
        dump_ready = 1'b0;
        stall_left--;
      end else begin
        dump_ready = 1'b1;
      end
      @(negedge clk);
      if (mem_rd_en && first_rd < 0) first_rd = cyc;
      if (prev_hold) begin
        chk({name, ".hold_valid"}, dump_valid, 1);
        chk({name, ".hold_data"}, dump_data, pd_data);
        chk({name, ".hold_core"}, dump_core, pd_core);
        chk({name, ".hold_addr"}, dump_addr, pd_addr);
        chk({name, ".hold_last"}, dump_last, pd_last);
      end
      if (dump_valid && dump_ready) begin
        chk({name, ".word_expected"}, exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk({name, ".dump_data"}, dump_data, e.data);
          chk({name, ".dump_core"}, dump_core, e.core);
          chk({name, ".dump_addr"}, dump_addr, e.addr);
          chk({name, ".dump_last"}, dump_last, e.last);
        end
        if (!stall && n_acc > 0) chk({name, ".accept_gap"}, cyc - last_acc, 2);
        $display("%s word %0d core=%0d addr=%0d data=%h last=%0b", name, n_acc,
                 dump_core, dump_addr, dump_data, dump_last);
        last_acc = cyc;
        n_acc++;
      end
      prev_hold = dump_valid && !dump_ready;
      pd_data = dump_data; pd_core = dump_core; pd_addr = dump_addr; pd_last = dump_last;
      if (done) begin
        finished = 1'b1;
        break;
      end
      if (abort_after > 0 && n_acc == abort_after) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk({name, ".flush_cycles"}, first_rd, FC);
    if (abort_after == 0) begin
      chk({name, ".finished"}, finished, 1);
      chk({name, ".words"}, n_acc, NC * DD);
      chk({name, ".queue_empty"}, exp_q.size(), 0);
      chk({name, ".done"}, done, 1);
      chk({name, ".busy_after"}, busy, 0);
      chk({name, ".valid_after"}, dump_valid, 0);
      chk({name, ".counts_kept"}, cycle_count, {32'(c1), 32'(c0)});
      if (stall) chk({name, ".stall_applied"}, stall_left, 0);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    dump_ready = 1'b0;
    inst_in = '1;
    seed = '0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    check_zero_outputs("reset");
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("idle.busy", busy, 0);
    chk("idle.done", done, 0);

    run_case("s1_stall", 10, 25, 1'b1, 0, 16'h1111);
    run_case("s1_rerun", 10, 25, 1'b0, 0, 16'h2222);
    run_case("timeout", 7, -1, 1'b0, 0, 16'h3333);
    run_case("tie", 5, 49, 1'b0, 0, 16'h4444);

    run_case("abort", 3, 4, 1'b0, 3, 16'h5555);
    chk("abort.rd_outstanding", mem_rd_en, 1);
    #1 reset = 1'b1;
    #1 check_zero_outputs("abort_reset");
    exp_q.delete();
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("post_reset.busy", busy, 0);

    run_case("first_cycle", 0, 12, 1'b0, 0, 16'h6666);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cardinal_run_monitor.md
Name: cardinal_run_monitor

Overview:
Synthesizable run controller and observer for multi-core NoC simulation and FPGA bring-up. It starts execution and counts cycles per core until each core fetches the halt instruction. After a fixed pipeline-flush interval, it streams every core's data memory out through a valid/ready port. It sits beside the cardinal_cpu instances and their dmem read ports, and replaces ad-hoc bench counting and dumping.

Parameters:
NUM_CORES, 4, number of monitored cores (>=1)
INST_WIDTH, 32, instruction width
HALT_INST, 32'h00000000, instruction value that marks end-of-program
CNT_WIDTH, 32, per-core and global cycle counter width
FLUSH_CYCLES, 5, cycles waited after the last halt before dumping (>=1)
TIMEOUT, 100000, global run cycles before a forced stop
DUMP_DEPTH, 128, words dumped per core
ADDR_WIDTH, 8, dmem word address width
DATA_WIDTH, 64, dmem word width
CORE_W, max(1,clog2(NUM_CORES)), core index width (derived)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  single-cycle start request
inst_in  in  NUM_CORES*INST_WIDTH  instruction fetched by each core; core c occupies slice [c*INST_WIDTH +: INST_WIDTH]
core_halted  out  NUM_CORES  bit c is set once core c has fetched HALT_INST
cycle_count  out  NUM_CORES*CNT_WIDTH  frozen per-core run cycle counts
total_cycles  out  CNT_WIDTH  global run cycle count
busy  out  1  high in RUN, FLUSH and DUMP
done  out  1  high in DONE
timed_out  out  1  the run ended by TIMEOUT
mem_rd_en  out  1  dmem read strobe
mem_core_sel  out  CORE_W  which core's dmem is read
mem_addr  out  ADDR_WIDTH  dmem read address
mem_rd_data  in  DATA_WIDTH  dmem read data, valid the cycle after mem_rd_en
dump_valid  out  1  dump word available
dump_ready  in  1  consumer accepts the dump word
dump_data  out  DATA_WIDTH  dump word
dump_core  out  CORE_W  core index of the dump word
dump_addr  out  ADDR_WIDTH  address of the dump word
dump_last  out  1  final word of the final core

Behaviour:
- Reset: state goes to IDLE. All counters, flags and outputs go to 0: busy, done, timed_out, core_halted, cycle_count, total_cycles, mem_rd_en, dump_valid, dump_last. Reset asserted in any state, including mid-DUMP with a read outstanding, abandons the operation immediately.
- IDLE: start=1 clears all counters and flags and moves to RUN on the next edge. All other inputs are ignored.
- RUN, every cycle:
  - total_cycles increments.
  - For each core c with core_halted[c]=0: if its inst_in slice equals HALT_INST, core_halted[c] sets and cycle_count[c] freezes at its current value. Otherwise cycle_count[c] increments.
  - Counters saturate at all-ones; they do not wrap.
  - A core that fetches the halt instruction on the first RUN cycle reports cycle_count=0.
- RUN exits:
  - All core_halted bits set -> FLUSH.
  - total_cycles reaches TIMEOUT-1 with some core still running -> FLUSH, timed_out=1, running cores' counts freeze.
  - If both conditions occur in the same cycle, the all-halted exit wins and timed_out stays 0.
- FLUSH: waits exactly FLUSH_CYCLES cycles, then moves to DUMP with core index 0 and address 0.
- DUMP handshake:
  - There is one output register and at most one outstanding read.
  - A read is issued (mem_rd_en=1, mem_core_sel, mem_addr driven) when no read is pending, reads remain, and either dump_valid=0 or dump_valid&&dump_ready in that cycle.
  - The next cycle's mem_rd_data is captured into dump_data, with dump_core and dump_addr tagged. dump_valid goes high the following cycle.
  - dump_data, dump_core, dump_addr and dump_last stay stable while dump_valid && !dump_ready.
  - Peak throughput is one word per 2 cycles.
  - Address order: addr 0..DUMP_DEPTH-1 within a core, then the next core; 0..NUM_CORES-1.
  - dump_last=1 only with core NUM_CORES-1, addr DUMP_DEPTH-1.
- DUMP exit: acceptance of the dump_last word moves to DONE.
- DONE: done=1. Counts and flags stay readable. start restarts: counters clear and the state moves to RUN.
- start is ignored in RUN, FLUSH and DUMP.

Test Plan:
1. NUM_CORES=2: core0 fetches HALT at RUN cycle 10, core1 at cycle 25 -> core_halted=2'b11, cycle_count={25,10} (core1 first), total_cycles=26, FLUSH 5 cycles, then the first mem_rd_en.
2. TIMEOUT=50, core1 never halts -> timed_out=1 and core1 count=49, with a normal dump afterwards.
3. DUMP_DEPTH=4 with dump_ready held low for 3 cycles on word 2 -> the output stays stable; 8 words appear in order with the correct core/addr tags, dump_last on core1/addr3, then done=1.
4. dump_ready tied high -> each word is accepted exactly 2 cycles after the previous one; no word is dropped or duplicated.
5. reset pulse mid-DUMP -> all outputs are 0 in the same cycle; a later start runs cleanly from zeroed counters.
6. start in DONE -> counters clear and a second run reproduces scenario 1's counts. A halt seen on the first RUN cycle gives count 0.
